score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Sequential producer of the 10-bit game score consumed by the score-to-digit split and seven-segment path. It is the writer end of the score interface.
- Accepts single-cycle game events from the ball/brick logic (brick hit with brick type, paddle hit, ball lost) and a start command from the keypad control decode.
- Maintains score, combo multiplier, lives and game state.
- Runs on the game-logic clock, alongside the keypad scanner.

Parameters:
- MAX_SCORE, 999, saturation ceiling; score never exceeds it.
- LIVES_INIT, 3, lives loaded on start; range 1..3.
- COMBO_MAX, 4, combo multiplier ceiling; range 1..7.

Ports:
- clock  input  1  game-logic clock (already divided); all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: begin or restart a game.
- brick_hit  input  1  one-cycle pulse: ball destroyed a brick.
- brick_type  input  2  qualified by brick_hit; base points 00→1, 01→2, 10→5, 11→10.
- paddle_hit  input  1  one-cycle pulse: ball bounced off the paddle.
- ball_lost  input  1  one-cycle pulse: ball fell past the paddle.
- score  output  10  current score, binary, 0..MAX_SCORE.
- lives  output  2  remaining lives.
- combo  output  3  current multiplier, 1..COMBO_MAX.
- playing  output  1  high in PLAY state.
- game_over  output  1  high in OVER state.
- score_update  output  1  one-cycle pulse in the cycle score takes a new, different value.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; score 0; lives LIVES_INIT; combo 1; playing 0; game_over 0; score_update 0.
- All outputs are registered. An event sampled at edge N is visible after edge N (1-cycle latency).
- States: IDLE(00), PLAY(01), OVER(10); code 11 is unreachable and recovers to IDLE on the next edge.
- IDLE:
  - start → PLAY, with score 0, lives LIVES_INIT, combo 1.
  - All other inputs are ignored.
- PLAY, start asserted:
  - Restart: score 0, lives LIVES_INIT, combo 1.
  - All other same-cycle events are ignored.
  - score_update pulses only if score was nonzero.
- PLAY, no start:
  - brick_hit:
    - Points = base(brick_type) × combo, using the pre-edge combo; maximum 40.
    - Sum is formed in 11 bits, then clamped to MAX_SCORE.
    - combo ← min(combo+1, COMBO_MAX).
  - paddle_hit: combo ← 1. Overrides the brick increment when coincident; the brick still scores with the old combo.
  - ball_lost: combo ← 1; lives ← lives−1. A coincident brick_hit still scores.
    - If lives was 1, the next state is OVER and game_over rises in the same edge.
    - Lives never underflows.
- OVER:
  - score, lives and combo are frozen; all events ignored.
  - start → PLAY with full clear, as from IDLE.
- score_update = 1 iff the registered score differs from its previous value. No pulse on a saturated hit (score already MAX_SCORE) or on start when score is 0.
- Pulses longer than one cycle are treated as one event per cycle. Edge detection is the producer's responsibility.
- Reset asserted mid-game returns immediately to reset values, regardless of pending events.

Test Plan:
- Reset low for 3 cycles, then high → score 0, lives 3, combo 1, playing 0, game_over 0, score_update 0.
- start, then brick_hit with types 00, 01, 10, 11 on consecutive cycles → score 1, 5, 20, 60; combo 2, 3, 4, 4; score_update high each cycle. Then paddle_hit → combo 1; next type-00 hit → score 61.
- Same cycle brick_hit type 11 + paddle_hit, with combo 3 and score 100 → score 130, combo 1. Same cycle brick_hit + ball_lost → points added, lives −1, combo 1.
- Saturation:
  - Score 990, combo 2: hit type 10 → score 999, score_update 1.
  - A further hit → score 999, score_update 0; combo still increments.
- Three ball_lost pulses → lives 2, 1, 0. game_over 1 and playing 0 after the third. A later brick_hit leaves score unchanged; start → score 0, lives 3, playing 1.
- Assert reset mid-cycle while in PLAY with score 250 → outputs return to reset values without waiting for a clock edge. After release, brick_hit is ignored until start.

Source files
------------

// File: rtl/score_keeper_if.sv
// Score interface: game events toward the score keeper and the score/status it publishes.
// The score keeper sits on the slave side; game logic or a testbench sits on the master side.
interface score_keeper_if;
    logic       start;
    logic       brick_hit;
    logic [1:0] brick_type;
    logic       paddle_hit;
    logic       ball_lost;
    logic [9:0] score;
    logic [1:0] lives;
    logic [2:0] combo;
    logic       playing;
    logic       game_over;
    logic       score_update;

    modport master (
        output start, brick_hit, brick_type, paddle_hit, ball_lost,
        input  score, lives, combo, playing, game_over, score_update
    );

    modport slave (
        input  start, brick_hit, brick_type, paddle_hit, ball_lost,
        output score, lives, combo, playing, game_over, score_update
    );
endinterface

// File: rtl/score_keeper.sv
// Game score keeper: accumulates brick points scaled by a combo multiplier,
// tracks lives and the IDLE/PLAY/OVER game state. All outputs are registered.
module score_keeper #(
    parameter int MAX_SCORE  = 999,
    parameter int LIVES_INIT = 3,
    parameter int COMBO_MAX  = 4
) (
    input  logic           clock,
    input  logic           reset,
    score_keeper_if.slave  sk
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    localparam logic [9:0] SCORE_CEIL = 10'(MAX_SCORE);
    localparam logic [1:0] LIVES_RST  = 2'(LIVES_INIT);
    localparam logic [2:0] COMBO_TOP  = 3'(COMBO_MAX);

    state_t     state_q, state_d;
    logic [9:0] score_q, score_d;
    logic [1:0] lives_q, lives_d;
    logic [2:0] combo_q, combo_d;
    logic       playing_q, game_over_q, update_q;

    logic [3:0]  base_pts;
    logic [6:0]  points;
    logic [10:0] sum;
    logic [9:0]  clamped;

    always_comb begin
        base_pts = 4'd1;
        case (sk.brick_type)
            2'b00:   base_pts = 4'd1;
            2'b01:   base_pts = 4'd2;
            2'b10:   base_pts = 4'd5;
            default: base_pts = 4'd10;
        endcase
    end

    // Sum is one bit wider than the score so the clamp sees a true overflow.
    assign points  = 7'(base_pts) * 7'(combo_q);
    assign sum     = {1'b0, score_q} + 11'(points);
    assign clamped = (sum > 11'(SCORE_CEIL)) ? SCORE_CEIL : sum[9:0];

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        combo_d = combo_q;
        case (state_q)
            IDLE, OVER: begin
                if (sk.start) begin
                    state_d = PLAY;
                    score_d = 10'd0;
                    lives_d = LIVES_RST;
                    combo_d = 3'd1;
                end
            end
            PLAY: begin
                if (sk.start) begin
                    score_d = 10'd0;
                    lives_d = LIVES_RST;
                    combo_d = 3'd1;
                end else begin
                    if (sk.brick_hit) begin
                        score_d = clamped;
                        combo_d = (combo_q >= COMBO_TOP) ? COMBO_TOP : combo_q + 3'd1;
                    end
                    // Paddle or lost ball resets the combo even when a brick scores.
                    if (sk.paddle_hit || sk.ball_lost) begin
                        combo_d = 3'd1;
                    end
                    if (sk.ball_lost && (lives_q != 2'd0)) begin
                        lives_d = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_d = OVER;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            score_q     <= 10'd0;
            lives_q     <= LIVES_RST;
            combo_q     <= 3'd1;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            combo_q     <= combo_d;
            playing_q   <= (state_d == PLAY);
            game_over_q <= (state_d == OVER);
            update_q    <= (score_d != score_q);
        end
    end

    assign sk.score        = score_q;
    assign sk.lives        = lives_q;
    assign sk.combo        = combo_q;
    assign sk.playing      = playing_q;
    assign sk.game_over    = game_over_q;
    assign sk.score_update = update_q;
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: one task per scenario, hand-computed expectations.
module tb_score_keeper;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    score_keeper_if sk ();

    score_keeper #(
        .MAX_SCORE (999),
        .LIVES_INIT(3),
        .COMBO_MAX (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sk   (sk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic ev(input logic st, input logic hit, input logic [1:0] ty,
                      input logic pad, input logic lost);
        @(negedge clock);
        sk.start      = st;
        sk.brick_hit  = hit;
        sk.brick_type = ty;
        sk.paddle_hit = pad;
        sk.ball_lost  = lost;
        @(posedge clock);
        #1;
        sk.start      = 1'b0;
        sk.brick_hit  = 1'b0;
        sk.brick_type = 2'b00;
        sk.paddle_hit = 1'b0;
        sk.ball_lost  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({sk.score, sk.lives, sk.combo, sk.playing, sk.game_over, sk.score_update}
            !== {10'd0, 2'd3, 3'd1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_held: score=%0d lives=%0d combo=%0d pl=%b go=%b up=%b, required 0 3 1 0 0 0",
                     sk.score, sk.lives, sk.combo, sk.playing, sk.game_over, sk.score_update);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({sk.score, sk.lives, sk.combo, sk.playing, sk.game_over, sk.score_update}
            !== {10'd0, 2'd3, 3'd1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_release: score=%0d lives=%0d combo=%0d pl=%b go=%b up=%b, required 0 3 1 0 0 0",
                     sk.score, sk.lives, sk.combo, sk.playing, sk.game_over, sk.score_update);
        end
        $display("reset: score=%0d lives=%0d combo=%0d", sk.score, sk.lives, sk.combo);
    endtask

    task automatic test_brick_chain();
        logic [1:0] types [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        int         exp_s [4] = '{1, 5, 20, 60};
        int         exp_c [4] = '{2, 3, 4, 4};
        ev(1, 0, 0, 0, 0);
        checks++;
        if ({sk.playing, sk.score, sk.combo, sk.score_update} !== {1'b1, 10'd0, 3'd1, 1'b0}) begin
            failures++;
            $display("FAIL chain_start: pl=%b score=%0d combo=%0d up=%b, required 1 0 1 0",
                     sk.playing, sk.score, sk.combo, sk.score_update);
        end
        for (int i = 0; i < 4; i++) begin
            ev(0, 1, types[i], 0, 0);
            checks++;
            if ({sk.score, sk.combo, sk.score_update} !== {10'(exp_s[i]), 3'(exp_c[i]), 1'b1}) begin
                failures++;
                $display("FAIL chain_hit%0d: score=%0d combo=%0d up=%b, required %0d %0d 1",
                         i, sk.score, sk.combo, sk.score_update, exp_s[i], exp_c[i]);
            end
            $display("hit type=%0d: score=%0d combo=%0d", types[i], sk.score, sk.combo);
        end
        ev(0, 0, 0, 1, 0);
        checks++;
        if ({sk.score, sk.combo, sk.score_update} !== {10'd60, 3'd1, 1'b0}) begin
            failures++;
            $display("FAIL chain_paddle: score=%0d combo=%0d up=%b, required 60 1 0",
                     sk.score, sk.combo, sk.score_update);
        end
        ev(0, 1, 0, 0, 0);
        checks++;
        if ({sk.score, sk.combo, sk.score_update} !== {10'd61, 3'd2, 1'b1}) begin
            failures++;
            $display("FAIL chain_after_paddle: score=%0d combo=%0d up=%b, required 61 2 1",
                     sk.score, sk.combo, sk.score_update);
        end
        $display("paddle then hit: score=%0d combo=%0d", sk.score, sk.combo);
    endtask

    task automatic test_coincident();
        ev(1, 0, 0, 0, 0);
        checks++;
        if ({sk.score, sk.score_update, sk.lives} !== {10'd0, 1'b1, 2'd3}) begin
            failures++;
            $display("FAIL restart_nonzero: score=%0d up=%b lives=%0d, required 0 1 3",
                     sk.score, sk.score_update, sk.lives);
        end
        // 10,30,60 | paddle | 70 | paddle | 80,100 -> score 100 with combo 3
        ev(0, 1, 3, 0, 0); ev(0, 1, 3, 0, 0); ev(0, 1, 3, 0, 0);
        ev(0, 0, 0, 1, 0); ev(0, 1, 3, 0, 0); ev(0, 0, 0, 1, 0);
        ev(0, 1, 3, 0, 0); ev(0, 1, 3, 0, 0);
        checks++;
        if ({sk.score, sk.combo} !== {10'd100, 3'd3}) begin
            failures++;
            $display("FAIL coin_setup: score=%0d combo=%0d, required 100 3", sk.score, sk.combo);
        end
        ev(0, 1, 3, 1, 0);
        checks++;
        if ({sk.score, sk.combo, sk.score_update} !== {10'd130, 3'd1, 1'b1}) begin
            failures++;
            $display("FAIL coin_brick_paddle: score=%0d combo=%0d up=%b, required 130 1 1",
                     sk.score, sk.combo, sk.score_update);
        end
        ev(0, 1, 1, 0, 1);
        checks++;
        if ({sk.score, sk.combo, sk.lives, sk.playing} !== {10'd132, 3'd1, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL coin_brick_lost: score=%0d combo=%0d lives=%0d pl=%b, required 132 1 2 1",
                     sk.score, sk.combo, sk.lives, sk.playing);
        end
        $display("coincident: score=%0d combo=%0d lives=%0d", sk.score, sk.combo, sk.lives);
    endtask

    task automatic test_saturation();
        ev(1, 0, 0, 0, 0);
        ev(0, 1, 3, 0, 0); ev(0, 1, 3, 0, 0); ev(0, 1, 3, 0, 0);
        repeat (23) ev(0, 1, 3, 0, 0);
        checks++;
        if ({sk.score, sk.combo, sk.lives} !== {10'd980, 3'd4, 2'd3}) begin
            failures++;
            $display("FAIL sat_climb: score=%0d combo=%0d lives=%0d, required 980 4 3",
                     sk.score, sk.combo, sk.lives);
        end
        ev(0, 0, 0, 1, 0);
        ev(0, 1, 3, 0, 0);
        checks++;
        if ({sk.score, sk.combo} !== {10'd990, 3'd2}) begin
            failures++;
            $display("FAIL sat_setup: score=%0d combo=%0d, required 990 2", sk.score, sk.combo);
        end
        ev(0, 1, 2, 0, 0);
        checks++;
        if ({sk.score, sk.combo, sk.score_update} !== {10'd999, 3'd3, 1'b1}) begin
            failures++;
            $display("FAIL sat_clamp: score=%0d combo=%0d up=%b, required 999 3 1",
                     sk.score, sk.combo, sk.score_update);
        end
        ev(0, 1, 0, 0, 0);
        checks++;
        if ({sk.score, sk.combo, sk.score_update} !== {10'd999, 3'd4, 1'b0}) begin
            failures++;
            $display("FAIL sat_hold: score=%0d combo=%0d up=%b, required 999 4 0",
                     sk.score, sk.combo, sk.score_update);
        end
        $display("saturation: score=%0d combo=%0d", sk.score, sk.combo);
    endtask

    task automatic test_lives();
        int exp_l [3] = '{2, 1, 0};
        for (int i = 0; i < 3; i++) begin
            ev(0, 0, 0, 0, 1);
            checks++;
            if ({sk.lives, sk.playing, sk.game_over, sk.combo}
                !== {2'(exp_l[i]), (i < 2), (i == 2), 3'd1}) begin
                failures++;
                $display("FAIL lives_%0d: lives=%0d pl=%b go=%b combo=%0d, required %0d %b %b 1",
                         i, sk.lives, sk.playing, sk.game_over, sk.combo, exp_l[i], (i < 2), (i == 2));
            end
            $display("ball_lost: lives=%0d game_over=%b", sk.lives, sk.game_over);
        end
        ev(0, 1, 3, 0, 1);
        checks++;
        if ({sk.score, sk.score_update, sk.lives, sk.game_over} !== {10'd999, 1'b0, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL over_frozen: score=%0d up=%b lives=%0d go=%b, required 999 0 0 1",
                     sk.score, sk.score_update, sk.lives, sk.game_over);
        end
        ev(1, 0, 0, 0, 0);
        checks++;
        if ({sk.score, sk.lives, sk.combo, sk.playing, sk.game_over, sk.score_update}
            !== {10'd0, 2'd3, 3'd1, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL over_restart: score=%0d lives=%0d combo=%0d pl=%b go=%b up=%b, required 0 3 1 1 0 1",
                     sk.score, sk.lives, sk.combo, sk.playing, sk.game_over, sk.score_update);
        end
        $display("restart from over: score=%0d lives=%0d", sk.score, sk.lives);
    endtask

    task automatic test_back_to_back();
        ev(1, 1, 3, 0, 1);
        checks++;
        if ({sk.score, sk.combo, sk.lives, sk.score_update, sk.playing}
            !== {10'd0, 3'd1, 2'd3, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL start_zero: score=%0d combo=%0d lives=%0d up=%b pl=%b, required 0 1 3 0 1",
                     sk.score, sk.combo, sk.lives, sk.score_update, sk.playing);
        end
        ev(0, 1, 2, 0, 0);
        ev(0, 1, 2, 0, 0);
        checks++;
        if ({sk.score, sk.combo, sk.score_update} !== {10'd15, 3'd3, 1'b1}) begin
            failures++;
            $display("FAIL b2b_hits: score=%0d combo=%0d up=%b, required 15 3 1",
                     sk.score, sk.combo, sk.score_update);
        end
        $display("back-to-back: score=%0d combo=%0d", sk.score, sk.combo);
    endtask

    task automatic test_midreset();
        ev(1, 0, 0, 0, 0);
        ev(0, 1, 3, 0, 0); ev(0, 1, 3, 0, 0); ev(0, 1, 3, 0, 0);
        repeat (4) ev(0, 1, 3, 0, 0);
        ev(0, 0, 0, 1, 0);
        ev(0, 1, 3, 0, 0); ev(0, 1, 3, 0, 0);
        checks++;
        if ({sk.score, sk.combo} !== {10'd250, 3'd3}) begin
            failures++;
            $display("FAIL midreset_setup: score=%0d combo=%0d, required 250 3", sk.score, sk.combo);
        end
        @(negedge clock);
        sk.brick_hit = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({sk.score, sk.lives, sk.combo, sk.playing, sk.game_over, sk.score_update}
            !== {10'd0, 2'd3, 3'd1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_async: score=%0d lives=%0d combo=%0d pl=%b go=%b up=%b, required 0 3 1 0 0 0",
                     sk.score, sk.lives, sk.combo, sk.playing, sk.game_over, sk.score_update);
        end
        @(negedge clock);
        sk.brick_hit = 1'b0;
        reset = 1'b1;
        ev(0, 1, 3, 0, 1);
        checks++;
        if ({sk.score, sk.lives, sk.playing, sk.score_update} !== {10'd0, 2'd3, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL idle_ignore: score=%0d lives=%0d pl=%b up=%b, required 0 3 0 0",
                     sk.score, sk.lives, sk.playing, sk.score_update);
        end
        ev(1, 0, 0, 0, 0);
        ev(0, 1, 1, 0, 0);
        checks++;
        if ({sk.playing, sk.score, sk.combo} !== {1'b1, 10'd2, 3'd2}) begin
            failures++;
            $display("FAIL idle_start: pl=%b score=%0d combo=%0d, required 1 2 2",
                     sk.playing, sk.score, sk.combo);
        end
        $display("mid-game reset and restart: score=%0d playing=%b", sk.score, sk.playing);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        sk.start      = 1'b0;
        sk.brick_hit  = 1'b0;
        sk.brick_type = 2'b00;
        sk.paddle_hit = 1'b0;
        sk.ball_lost  = 1'b0;
        test_reset();
        test_brick_chain();
        test_coincident();
        test_saturation();
        test_lives();
        test_back_to_back();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
